// File: rtl/cpu_mc_core.sv
// Multi-cycle 16-bit-ISA CPU core with a single req/ready memory port.
// Each instruction is fetched, executed, and, for LD/ST, followed by one
// data access. Any number of memory wait states is tolerated.
// Optional feature: define CPU_RETIRE_PORT_EN to add retire_valid_o/retire_pc_o.
// reset_i is asynchronous and active low.
module cpu_mc_core #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NREGS    = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
`ifdef CPU_RETIRE_PORT_EN
    ,
    output logic              retire_valid_o,
    output logic [ADDR_W-1:0] retire_pc_o
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ALU  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_BZ   = 4'h7;
    localparam logic [3:0] OP_BC   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                z_q, z_d, c_q, c_d;
    // Runs one cycle behind reset release so the port stays idle until the first edge.
    logic                run_q;
    // 16 entries cover every encodable index; entries >= NREGS are never written and read as 0.
    logic [DATA_W-1:0]   rf_q [16];
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;

    logic [3:0]          op, rd, rs, fn;
    logic [DATA_W-1:0]   rd_val, rs_val;
    logic [ADDR_W-1:0]   imm12;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c, alu_ok;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign rs     = ir_q[7:4];
    assign fn     = ir_q[3:0];
    assign imm12  = ADDR_W'(ir_q[11:0]);
    assign rd_val = rf_q[rd];
    assign rs_val = rf_q[rs];

    assign busy_o   = run_q && (state_q != S_HALT);
    assign halted_o = (state_q == S_HALT);

    // ALU: both operands come from the old register values, so rd==rs is safe.
    always_comb begin
        alu_ok  = 1'b1;
        alu_c   = 1'b0;
        alu_res = '0;
        case (fn)
            4'h0: {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
            4'h1: {alu_c, alu_res} = {1'b0, rd_val} - {1'b0, rs_val};
            4'h2: alu_res = rd_val & rs_val;
            4'h3: alu_res = rd_val | rs_val;
            4'h4: alu_res = rd_val ^ rs_val;
            4'h5: alu_res = ~rs_val;
            4'h6: {alu_c, alu_res} = {rd_val, 1'b0};
            4'h7: begin
                alu_res = {1'b0, rd_val[DATA_W-1:1]};
                alu_c   = rd_val[0];
            end
            default: alu_ok = 1'b0;
        endcase
    end

    // Next-state, register write-back and memory port drive.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        z_d         = z_q;
        c_d         = c_q;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = pc_q;
                    if (mem_ready_i) begin
                        ir_d    = mem_rdata_i[15:0];
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (op)
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = DATA_W'(ir_q[7:0]);
                        end
                        OP_MOV: begin
                            rf_we    = 1'b1;
                            rf_wdata = rs_val;
                        end
                        OP_ALU: if (alu_ok) begin
                            rf_we    = 1'b1;
                            rf_wdata = alu_res;
                            z_d      = (alu_res == '0);
                            c_d      = alu_c;
                        end
                        OP_LD, OP_ST: state_d = S_MEM;
                        OP_JMP:  pc_d = imm12;
                        OP_BZ:   if (z_q) pc_d = imm12;
                        OP_BC:   if (c_q) pc_d = imm12;
                        OP_HALT: state_d = S_HALT;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = (op == OP_ST);
                    mem_addr_o  = ADDR_W'(rs_val);
                    mem_wdata_o = rd_val;
                    if (mem_ready_i) begin
                        state_d = S_FETCH;
                        if (op == OP_LD) begin
                            rf_we    = 1'b1;
                            rf_wdata = mem_rdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, PC, IR, flags and register file.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            run_q   <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            run_q   <= 1'b1;
            if (rf_we && (int'(rd) < NREGS)) rf_q[rd] <= rf_wdata;
        end
    end

`ifdef CPU_RETIRE_PORT_EN
    logic              retire_d;
    logic              retire_valid_q;
    logic [ADDR_W-1:0] retire_pc_q, ipc_q;

    // LD/ST retire on data accept; everything else (HALT included) on leaving EXEC.
    assign retire_d = ((state_q == S_EXEC) && (op != OP_LD) && (op != OP_ST)) ||
                      ((state_q == S_MEM) && mem_ready_i);
    assign retire_valid_o = retire_valid_q;
    assign retire_pc_o    = retire_pc_q;

    // Remember each instruction's own address and report it when it retires.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            ipc_q          <= '0;
        end else begin
            retire_valid_q <= retire_d;
            if (retire_d) retire_pc_q <= ipc_q;
            if (run_q && (state_q == S_FETCH) && mem_ready_i) ipc_q <= pc_q;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mc_core.sv
// Bench for cpu_mc_core: behavioural memory with programmable wait states,
// expected stores held in a scoreboard queue and matched as the core writes.
module tb_cpu_mc_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, halted, mem_req, mem_we, mem_ready = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
`ifdef CPU_RETIRE_PORT_EN
    logic        retire_valid;
    logic [15:0] retire_pc;
`endif

    cpu_mc_core dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .busy_o      (busy),
        .halted_o    (halted),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready)
`ifdef CPU_RETIRE_PORT_EN
        ,
        .retire_valid_o (retire_valid),
        .retire_pc_o    (retire_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [15:0] exp_ret[$];
    logic [15:0] mem [256];
    int          n_chk = 0, n_err = 0;
    int          wait_n = 0, wcnt = 0;
    bit          pend = 0, p_we = 0, ret_on = 0;
    logic [15:0] p_addr = '0, p_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Memory responder: decides ready on the falling edge, commits a transfer
    // on the following falling edge (the rising edge in between accepted it).
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            pend      = 0;
        end else begin
            if (pend) begin
                pend = 0;
                wcnt = 0;
                if (p_we) begin
                    mem[p_addr[7:0]] = p_wdata;
                    if (exp_wr.size() == 0) chk("unexp_wr", p_addr, 16'hFFFF);
                    else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", p_addr, e.a);
                        chk("wr_data", p_wdata, e.d);
                    end
                end
            end
            mem_ready = 1'b0;
            if (mem_req) begin
                if (wcnt >= wait_n) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[7:0]];
                    pend      = 1;
                    p_we      = mem_we;
                    p_addr    = mem_addr;
                    p_wdata   = mem_wdata;
                end else wcnt++;
            end
        end
`ifdef CPU_RETIRE_PORT_EN
        if (rst_n && ret_on && retire_valid) begin
            if (exp_ret.size() == 0) chk("unexp_ret", retire_pc, 16'hFFFF);
            else chk("retire_pc", retire_pc, exp_ret.pop_front());
        end
`endif
    end

    task automatic put(input int a, input logic [15:0] w);
        mem[a] = w;
    endtask

    task automatic exp_w(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic rst_on();
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic rst_off();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt", halted, 1);
        chk("wr_left", exp_wr.size(), 0);
        exp_wr.delete();
    endtask

    // Long program: arithmetic, flags, branches, LD/ST, dropped register index.
    task automatic load_p2();
        clr_mem();
        put(8'h00, 16'h1105); put(8'h01, 16'h1203); put(8'h02, 16'h3120);
        put(8'h03, 16'h1780); put(8'h04, 16'h5170); put(8'h05, 16'h7020);
        put(8'h06, 16'h8020); put(8'h07, 16'h1300); put(8'h08, 16'h3331);
        put(8'h09, 16'h7010);
        put(8'h10, 16'h14FF); put(8'h11, 16'h1501); put(8'h12, 16'h3541);
        put(8'h13, 16'h8030);
        put(8'h20, 16'h5770);
        put(8'h30, 16'h5570); put(8'h31, 16'h4670); put(8'h32, 16'h2060);
        put(8'h33, 16'h1855); put(8'h34, 16'h2180); put(8'h35, 16'h1781);
        put(8'h36, 16'h5070); put(8'h37, 16'h5170); put(8'h38, 16'h11FF);
        for (int i = 0; i < 8; i++) put(8'h39 + i, 16'h3116);
        put(8'h41, 16'h5170);
        for (int i = 0; i < 8; i++) put(8'h42 + i, 16'h3116);
        put(8'h4A, 16'h5170); put(8'h4B, 16'h8050);
        put(8'h50, 16'h7060);
        put(8'h60, 16'h120F); put(8'h61, 16'h133C); put(8'h62, 16'h3234);
        put(8'h63, 16'h5270); put(8'h64, 16'h3232); put(8'h65, 16'h5270);
        put(8'h66, 16'h3233); put(8'h67, 16'h5270); put(8'h68, 16'h3235);
        put(8'h69, 16'h3227); put(8'h6A, 16'h8070);
        put(8'h70, 16'h5270); put(8'h71, 16'h9ABC); put(8'h72, 16'h3238);
        put(8'h73, 16'h8078);
        put(8'h78, 16'h5270); put(8'h79, 16'h3225); put(8'h7A, 16'h3220);
        put(8'h7B, 16'h807E);
        put(8'h7E, 16'h5270);
        exp_w(16'h80, 16'h0008);
        exp_w(16'h80, 16'hFF02);
        exp_w(16'h81, 16'hFF02);
        exp_w(16'h81, 16'h0000);
        exp_w(16'h81, 16'hFF00);
        exp_w(16'h81, 16'h0000);
        exp_w(16'h81, 16'h0033);
        exp_w(16'h81, 16'h0030);
        exp_w(16'h81, 16'h003C);
        exp_w(16'h81, 16'h7FE1);
        exp_w(16'h81, 16'h7FE1);
        exp_w(16'h81, 16'h003C);
    endtask

    initial begin
        bit seen;
        clr_mem();
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
`ifdef CPU_RETIRE_PORT_EN
        chk("rst_ret_v", retire_valid, 0);
        chk("rst_ret_pc", retire_pc, 0);
`endif

        // LDI, LDI, ADD, HALT with zero wait: halted after 9 clocks
        put(0, 16'h1105); put(1, 16'h1203); put(2, 16'h3120); put(3, 16'hF000);
`ifdef CPU_RETIRE_PORT_EN
        for (int i = 0; i < 4; i++) exp_ret.push_back(16'(i));
        ret_on = 1;
`endif
        rst_n = 1'b1;
        chk("rel_req", mem_req, 0);
        @(negedge clk);
        chk("first_busy", busy, 1);
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);
        repeat (7) @(negedge clk);
        chk("halt_8clk", halted, 0);
        @(negedge clk);
        chk("halt_9clk", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_req", mem_req, 0);
        repeat (2) @(negedge clk);
        ret_on = 0;
        chk("ret_left", exp_ret.size(), 0);

        // Full program, zero wait and two wait states
        foreach (wait_n_tab[k]) begin
            rst_on();
            wait_n = wait_n_tab[k];
            load_p2();
            rst_off();
            run_halt(6000);
        end

        // Store held stable through three not-ready cycles
        rst_on();
        wait_n = 3;
        clr_mem();
        put(0, 16'h115A); put(1, 16'h1290); put(2, 16'h5120);
        exp_w(16'h90, 16'h5A);
        rst_off();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req && mem_we;
        end
        chk("st_seen", seen, 1);
        for (int i = 0; i < 4; i++) begin
            chk("st_req", mem_req, 1);
            chk("st_we", mem_we, 1);
            chk("st_addr", mem_addr, 16'h90);
            chk("st_wdata", mem_wdata, 16'h5A);
            @(negedge clk);
        end
        chk("st_done", mem_we, 0);
        run_halt(200);

        // Reset during a stalled load
        rst_on();
        wait_n = 5;
        clr_mem();
        put(0, 16'h1177); put(1, 16'h1290); put(2, 16'h4320);
        rst_off();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req && !mem_we && (mem_addr == 16'h90);
        end
        chk("ld_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        clr_mem();
        put(0, 16'h5120); put(1, 16'h1401);
        exp_w(16'h0000, 16'h0000);
        @(negedge clk);
        rst_off();
        @(negedge clk);
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", mem_addr, 0);
        run_halt(300);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    int wait_n_tab [2] = '{0, 2};

endmodule
